// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch stage: streams sequential bytes from synchronous memory into a PC-tagged FIFO.
// Optional halt-opcode stop (8'h00) is compiled in when HALT_STOP_EN is defined.
module instr_prefetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready,
  output logic          halted
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state, state_next;
  logic [AW-1:0] fetch_pc, inflight_pc;
  logic          inflight;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [PW+1:0] occupancy;
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [DW-1:0] instr_mem [DEPTH];
  logic          push, pop, flush, halt_hit;

  assign flush     = redirect && (state != IDLE);
  assign push      = inflight && !redirect && (state != HALT);
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign mem_addr  = fetch_pc;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

`ifdef HALT_STOP_EN
  assign halt_hit = push && (mem_rdata == '0);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = RUN;
      RUN:     if (!redirect && halt_hit) state_next = HALT;
      HALT:    if (redirect) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Pops in the same cycle are not credited, so a full FIFO blocks requests for one extra cycle.
  always_comb begin
    mem_req   = (state == RUN) && !redirect && (occupancy < (PW+2)'(DEPTH));
    out_valid = (count != '0) && !redirect;
`ifdef HALT_STOP_EN
    halted    = (state == HALT);
`else
    halted    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      inflight <= mem_req;
      if (mem_req) begin
        fetch_pc    <= fetch_pc + AW'(1);
        inflight_pc <= fetch_pc;
      end
      if (flush) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= inflight_pc;
          instr_mem[wr_ptr] <= mem_rdata;
          wr_ptr            <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + (PW+1)'(1);
        else if (!push && pop) count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: a synchronous memory model plus an expected-output queue.
// Halt-opcode checks follow HALT_STOP_EN, matching the build of the design.
module tb_instr_prefetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       out_ready = 1'b0;
  logic       halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [7:0] pc; logic [7:0] instr;} ent_t;
  ent_t exp_q[$];

  logic       halt_on = 1'b0;
  logic [7:0] halt_addr = 8'h03;

  instr_prefetch_unit #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return (halt_on && a == halt_addr) ? 8'h00 : a + 8'h10;
  endfunction

  always @(posedge clk) if (mem_req) mem_rdata <= mem_val(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] pc);
    exp_q.push_back({pc, mem_val(pc)});
  endtask

  // Every accepted handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      ent_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_output observed_pc=%0h expected=none", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc", {24'h0, out_pc}, {24'h0, e.pc});
        chk("out_instr", {24'h0, out_instr}, {24'h0, e.instr});
      end
    end
  end

  // Leaves the bench at posedge+1 with out_ready low once every expected entry is seen.
  task automatic drain(input int max);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < max);
    chk("drain_left", exp_q.size(), 0);
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  // Asserts reset between edges; returns at posedge+1 just after release (cycle 0).
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic stream_check();
    for (int p = 0; p < 8; p++) push_exp(8'(p));
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c == 0) chk("c0_mem_req", mem_req, 0);
      if (c == 1) begin
        chk("c1_mem_req", mem_req, 1);
        chk("c1_mem_addr", mem_addr, 0);
      end
      chk($sformatf("valid_c%0d", c), out_valid, (c >= 3) ? 1 : 0);
      if (c == 3) chk("first_pc", out_pc, 0);
    end
    drain(4);
  endtask

  initial begin
    @(negedge clk);
    out_ready = 1'b1;
    do_reset();
    stream_check();

    // Stall: FIFO fills, then one pop re-enables requests on the following cycle.
    out_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    chk("stall_mem_req", mem_req, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_head_pc", out_pc, 0);
    for (int p = 0; p < 5; p++) push_exp(8'(p));
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("stall_req_pop_cycle", mem_req, 0);
    @(negedge clk);
    chk("stall_req_after_pop", mem_req, 1);
    chk("stall_addr_after_pop", mem_addr, 4);
    drain(20);

    // Redirect with three entries queued and one response in flight.
    do_reset();
    repeat (10) @(negedge clk);
    push_exp(8'h00);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pre_redir_req", mem_req, 1);
    chk("pre_redir_addr", mem_addr, 4);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    out_ready = 1'b1;
    push_exp(8'h40); push_exp(8'h41); push_exp(8'h42);
    @(negedge clk);
    chk("redir_valid_gated", out_valid, 0);
    chk("redir_req_gated", mem_req, 0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("redir_n1_req", mem_req, 1);
    chk("redir_n1_addr", mem_addr, 8'h40);
    chk("redir_n1_valid", out_valid, 0);
    @(negedge clk); chk("redir_n2_valid", out_valid, 0);
    @(negedge clk);
    chk("redir_n3_valid", out_valid, 1);
    chk("redir_n3_pc", out_pc, 8'h40);
    drain(10);

    // Address wrap after redirect near the top of the space.
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    out_ready = 1'b1;
    push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
    @(posedge clk); #1 redirect = 1'b0;
    drain(10);

    // Halt opcode at pc 3.
    halt_on = 1'b1;
    out_ready = 1'b1;
    do_reset();
`ifdef HALT_STOP_EN
    for (int p = 0; p < 4; p++) push_exp(8'(p));
    drain(15);
    @(negedge clk); chk("halted_set", halted, 1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halt_req_%0d", c), mem_req, 0);
      chk($sformatf("halt_valid_%0d", c), out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 8'h10;
    out_ready = 1'b1;
    push_exp(8'h10);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk); chk("halted_clear", halted, 0);
    drain(10);
`else
    for (int p = 0; p < 6; p++) push_exp(8'(p));
    drain(15);
    @(negedge clk); chk("no_halt_flag", halted, 0);
`endif
    halt_on = 1'b0;

    // Reset mid-stream, then the reset-release sequence must repeat.
    @(posedge clk); #1 out_ready = 1'b1;
    do_reset();
    push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
    repeat (6) @(negedge clk);
    #1;
    chk("pre_reset_drained", exp_q.size(), 0);
    chk("pre_reset_valid", out_valid, 1);
    do_reset();
    stream_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
